rggen_indirect_register_pipelined: RTL and testbench

Indirect register slave with a registered access pipeline. It decodes the address range and a masked index, captures the request, waits a fixed number of cycles, then performs a single-cycle bit-field access and responds. Index misses can optionally return a slave error. It sits between the rggen bus-protocol adapter (`register_if`) and a register's bit fields (`bit_field_if`). It serves slow-to-settle index sources and bit fields that need wait states.

---
 rtl/rggen_indirect_register_pipelined_pkg.sv | 16 +
 rtl/rggen_rtl_pkg.sv | 21 ++
 rtl/rggen_bit_field_if.sv | 26 ++
 rtl/rggen_register_if.sv | 31 +++
 rtl/rggen_address_decoder.sv | 22 ++
 rtl/rggen_indirect_register_pipelined.sv | 152 +++++++++++++++
 tb/tb_rggen_indirect_register_pipelined.sv | 286 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/rggen_indirect_register_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// rggen_indirect_register_pipelined_pkg : sizing helpers for the wait counter
// Revision: 1.0
// ============================================================================
package rggen_indirect_register_pipelined_pkg;

    localparam int MAX_WAIT_CYCLES = 255;

    // A counter that is loaded with WAIT_CYCLES-1 and stops at zero.
    function automatic int calc_counter_width(input int wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// ============================================================================
// rggen_rtl_pkg : shared bus direction and response status encodings
// Revision: 1.0
// ============================================================================
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage
`default_nettype wire

// File: rtl/rggen_bit_field_if.sv
`default_nettype none
// ============================================================================
// rggen_bit_field_if : access strobes and data between register and bit fields
// Revision: 1.0
// ============================================================================
interface rggen_bit_field_if #(
    parameter int WIDTH = 32
);
    logic               read_access;
    logic               write_access;
    logic [WIDTH-1:0]   write_data;
    logic [WIDTH-1:0]   write_mask;
    logic [WIDTH-1:0]   read_data;
    logic [WIDTH-1:0]   value;

    modport master (
        output read_access, write_access, write_data, write_mask,
        input  read_data, value
    );

    modport slave (
        input  read_access, write_access, write_data, write_mask,
        output read_data, value
    );
endinterface
`default_nettype wire

// File: rtl/rggen_register_if.sv
`default_nettype none
// ============================================================================
// rggen_register_if : request/response channel between bus adapter and register
// Revision: 1.0
// ============================================================================
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int VALUE_WIDTH   = BUS_WIDTH
);
    logic                               request;
    logic [ADDRESS_WIDTH-1:0]           address;
    rggen_rtl_pkg::rggen_direction      direction;
    logic [BUS_WIDTH-1:0]               write_data;
    logic [BUS_WIDTH-1:0]               write_mask;
    logic                               ready;
    rggen_rtl_pkg::rggen_status         status;
    logic [BUS_WIDTH-1:0]               read_data;
    logic [VALUE_WIDTH-1:0]             value;

    modport master (
        output request, address, direction, write_data, write_mask,
        input  ready, status, read_data, value
    );

    modport slave (
        input  request, address, direction, write_data, write_mask,
        output ready, status, read_data, value
    );
endinterface
`default_nettype wire

// File: rtl/rggen_address_decoder.sv
`default_nettype none
// ============================================================================
// rggen_address_decoder : flags a byte address inside [START_ADDRESS, END_ADDRESS]
// Revision: 1.0
// ============================================================================
module rggen_address_decoder #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter bit [ADDRESS_WIDTH-1:0]   START_ADDRESS = '0,
    parameter bit [ADDRESS_WIDTH-1:0]   END_ADDRESS   = '0
) (
    input  var logic [ADDRESS_WIDTH-1:0]    address,
    output var logic                        match
);
    localparam bit [ADDRESS_WIDTH-1:0] SPAN = END_ADDRESS - START_ADDRESS;

    // Offset compare keeps a single unsigned test even when START_ADDRESS is zero.
    logic [ADDRESS_WIDTH-1:0] offset;

    assign offset = address - START_ADDRESS;
    assign match  = (offset <= SPAN);
endmodule
`default_nettype wire

// File: rtl/rggen_indirect_register_pipelined.sv
`default_nettype none
// ============================================================================
// rggen_indirect_register_pipelined : indirect register with capture, wait states
// and a single-cycle bit-field access.  Revision: 1.0
// ============================================================================
module rggen_indirect_register_pipelined
    import rggen_rtl_pkg::*;
    import rggen_indirect_register_pipelined_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter bit [ADDRESS_WIDTH-1:0]   START_ADDRESS = '0,
    parameter bit [ADDRESS_WIDTH-1:0]   END_ADDRESS   = '0,
    parameter int                       INDEX_WIDTH   = 1,
    parameter bit [INDEX_WIDTH-1:0]     INDEX_VALUE   = '0,
    parameter bit [INDEX_WIDTH-1:0]     INDEX_MASK    = '1,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       WAIT_CYCLES   = 0,
    parameter bit                       ERROR_ON_MISS = 1'b0
) (
    input  var logic                    clk,
    input  var logic                    rst_n,
    rggen_register_if.slave             register_if,
    rggen_bit_field_if.master           bit_field_if,
    input  var logic [INDEX_WIDTH-1:0]  i_index
);
    localparam int COUNTER_WIDTH = calc_counter_width(WAIT_CYCLES);
    localparam bit [COUNTER_WIDTH-1:0] COUNTER_LOAD =
        COUNTER_WIDTH'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_WAIT   = 2'd1,
        STATE_ACCESS = 2'd2
    } state_e;

    state_e                     state;
    logic [COUNTER_WIDTH-1:0]   counter;
    rggen_direction             direction;
    logic [DATA_WIDTH-1:0]      write_data;
    logic [DATA_WIDTH-1:0]      write_mask;
    logic                       miss;
    logic                       ready;
    logic                       read_access;
    logic                       write_access;
    rggen_status                status;

    logic                       address_match;
    logic                       index_hit;
    logic                       select;
    logic                       capture;
    logic                       launch;
    logic                       access_hit;
    rggen_direction             access_direction;

    rggen_address_decoder #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .START_ADDRESS  (START_ADDRESS),
        .END_ADDRESS    (END_ADDRESS)
    ) u_address_decoder (
        .address    (register_if.address),
        .match      (address_match)
    );

    assign index_hit = (((i_index ^ INDEX_VALUE) & INDEX_MASK) == '0);
    assign select    = address_match && (index_hit || ERROR_ON_MISS);
    assign capture   = (state == STATE_IDLE) && register_if.request && select;

    // With no wait states the access launches from the bus values being captured.
    always_comb begin
        access_hit       = !miss;
        access_direction = direction;
        launch           = 1'b0;
        if (state == STATE_IDLE) begin
            access_hit       = index_hit;
            access_direction = register_if.direction;
            launch           = capture && (WAIT_CYCLES == 0);
        end else if (state == STATE_WAIT) begin
            launch           = register_if.request && (counter == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= STATE_IDLE;
            counter      <= '0;
            direction    <= RGGEN_READ;
            write_data   <= '0;
            write_mask   <= '0;
            miss         <= 1'b0;
            ready        <= 1'b0;
            read_access  <= 1'b0;
            write_access <= 1'b0;
            status       <= RGGEN_OKAY;
        end else begin
            ready        <= 1'b0;
            read_access  <= 1'b0;
            write_access <= 1'b0;
            status       <= RGGEN_OKAY;

            case (state)
                STATE_IDLE: begin
                    if (capture) begin
                        direction  <= register_if.direction;
                        write_data <= register_if.write_data;
                        write_mask <= register_if.write_mask;
                        miss       <= !index_hit;
                        if (WAIT_CYCLES > 0) begin
                            state   <= STATE_WAIT;
                            counter <= COUNTER_LOAD;
                        end else begin
                            state   <= STATE_ACCESS;
                        end
                    end
                end
                STATE_WAIT: begin
                    if (!register_if.request) begin
                        state   <= STATE_IDLE;
                        counter <= '0;
                    end else if (counter == '0) begin
                        state   <= STATE_ACCESS;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                STATE_ACCESS: begin
                    state <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase

            if (launch) begin
                ready        <= 1'b1;
                status       <= access_hit ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
                write_access <= access_hit && (access_direction == RGGEN_WRITE);
                read_access  <= access_hit && (access_direction == RGGEN_READ);
            end
        end
    end

    assign register_if.ready     = ready;
    assign register_if.status    = status;
    assign register_if.read_data = ((state == STATE_ACCESS) && !miss) ? bit_field_if.read_data : '0;
    assign register_if.value     = bit_field_if.value;

    assign bit_field_if.read_access  = read_access;
    assign bit_field_if.write_access = write_access;
    assign bit_field_if.write_data   = write_data;
    assign bit_field_if.write_mask   = write_mask;
endmodule
`default_nettype wire

// File: tb/tb_rggen_indirect_register_pipelined.sv
`default_nettype none
// ============================================================================
// tb_rggen_indirect_register_pipelined : scoreboard bench over three DUT configs
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rggen_indirect_register_pipelined;
    import rggen_rtl_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int WAITS [N] = '{0, 3, 4};

    typedef struct {
        int             lat;
        bit             wr;
        bit             rd;
        rggen_status    st;
        logic [DW-1:0]  rd_data;
        logic [DW-1:0]  wr_data;
        logic [DW-1:0]  wr_mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           req      [N];
    rggen_direction dir      [N];
    logic [AW-1:0]  addr     [N];
    logic [DW-1:0]  wdata    [N];
    logic [DW-1:0]  wmask    [N];
    logic [IW-1:0]  idx      [N];
    logic [DW-1:0]  bf_rdata [N];
    logic [DW-1:0]  bf_value [N];
    logic           rdy      [N];
    rggen_status    stat     [N];
    logic [DW-1:0]  rdata    [N];
    logic [DW-1:0]  rval     [N];
    logic [DW-1:0]  bf_wdata [N];
    logic [DW-1:0]  bf_wmask [N];
    logic           wacc     [N];
    logic           racc     [N];

    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    rggen_register_if  #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) reg_if [N] ();
    rggen_bit_field_if #(.WIDTH(DW))                         bf_if  [N] ();

    for (genvar g = 0; g < N; g++) begin : g_conn
        assign reg_if[g].request    = req[g];
        assign reg_if[g].address    = addr[g];
        assign reg_if[g].direction  = dir[g];
        assign reg_if[g].write_data = wdata[g];
        assign reg_if[g].write_mask = wmask[g];
        assign rdy[g]               = reg_if[g].ready;
        assign stat[g]              = reg_if[g].status;
        assign rdata[g]             = reg_if[g].read_data;
        assign rval[g]              = reg_if[g].value;
        assign bf_if[g].read_data   = bf_rdata[g];
        assign bf_if[g].value       = bf_value[g];
        assign wacc[g]              = bf_if[g].write_access;
        assign racc[g]              = bf_if[g].read_access;
        assign bf_wdata[g]          = bf_if[g].write_data;
        assign bf_wmask[g]          = bf_if[g].write_mask;
    end

    rggen_indirect_register_pipelined #(
        .ADDRESS_WIDTH(AW), .START_ADDRESS(16'h0010), .END_ADDRESS(16'h0013),
        .INDEX_WIDTH(IW), .INDEX_VALUE(4'd3), .INDEX_MASK(4'hF),
        .DATA_WIDTH(DW), .WAIT_CYCLES(0), .ERROR_ON_MISS(1'b0)
    ) dut_a (.clk(clk), .rst_n(rst_n), .register_if(reg_if[0]), .bit_field_if(bf_if[0]), .i_index(idx[0]));

    rggen_indirect_register_pipelined #(
        .ADDRESS_WIDTH(AW), .START_ADDRESS(16'h0010), .END_ADDRESS(16'h0013),
        .INDEX_WIDTH(IW), .INDEX_VALUE(4'd5), .INDEX_MASK(4'hF),
        .DATA_WIDTH(DW), .WAIT_CYCLES(3), .ERROR_ON_MISS(1'b1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .register_if(reg_if[1]), .bit_field_if(bf_if[1]), .i_index(idx[1]));

    rggen_indirect_register_pipelined #(
        .ADDRESS_WIDTH(AW), .START_ADDRESS(16'h0010), .END_ADDRESS(16'h0013),
        .INDEX_WIDTH(IW), .INDEX_VALUE(4'b0100), .INDEX_MASK(4'b1100),
        .DATA_WIDTH(DW), .WAIT_CYCLES(4), .ERROR_ON_MISS(1'b0)
    ) dut_c (.clk(clk), .rst_n(rst_n), .register_if(reg_if[2]), .bit_field_if(bf_if[2]), .i_index(idx[2]));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input rggen_direction dr, input logic [DW-1:0] wd,
                            input logic [DW-1:0] wm, input bit hit, input int lat);
        exp_t e;
        e.lat     = lat;
        e.wr      = hit && (dr == RGGEN_WRITE);
        e.rd      = hit && (dr == RGGEN_READ);
        e.st      = hit ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
        e.rd_data = hit ? bf_rdata[d] : '0;
        e.wr_data = wd;
        e.wr_mask = wm;
        sb.push_back(e);
    endtask

    task automatic drive(input int d, input rggen_direction dr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm, input logic [IW-1:0] ix);
        dir[d]   = dr;
        addr[d]  = a;
        wdata[d] = wd;
        wmask[d] = wm;
        idx[d]   = ix;
        req[d]   = 1'b1;
    endtask

    task automatic wait_resp(input int d, input string tag, input int elapsed, input bit hold);
        bit   got   = 1'b0;
        bit   early = 1'b0;
        int   n     = elapsed;
        exp_t e;
        while (!got && n < elapsed + 20) begin
            @(posedge clk); #1;
            n++;
            if (rdy[d]) got = 1'b1;
            else if (wacc[d] || racc[d]) early = 1'b1;
        end
        check({tag, "_ready"}, got, 1);
        check({tag, "_early_strobe"}, early, 0);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, n, e.lat);
            check({tag, "_status"}, stat[d], e.st);
            check({tag, "_read_data"}, rdata[d], e.rd_data);
            check({tag, "_write_access"}, wacc[d], e.wr);
            check({tag, "_read_access"}, racc[d], e.rd);
            if (e.wr) begin
                check({tag, "_bf_write_data"}, bf_wdata[d], e.wr_data);
                check({tag, "_bf_write_mask"}, bf_wmask[d], e.wr_mask);
            end
        end
        if (!hold) begin
            req[d] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_silence(input int d, input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (rdy[d] || wacc[d] || racc[d]) seen++;
        end
        check({tag, "_silent"}, seen, 0);
        req[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; dir[i] = RGGEN_READ; addr[i] = '0;
            wdata[i] = '0; wmask[i] = '0; idx[i] = '0;
        end
        bf_rdata[0] = 32'hDEAD_BEEF; bf_value[0] = 32'h0000_00A0;
        bf_rdata[1] = 32'h0000_1234; bf_value[1] = 32'h0000_00B1;
        bf_rdata[2] = 32'h5A5A_0F0F; bf_value[2] = 32'h0000_00C2;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_ready_%0d", i), rdy[i], 0);
            check($sformatf("reset_status_%0d", i), stat[i], RGGEN_OKAY);
            check($sformatf("reset_read_data_%0d", i), rdata[i], 0);
            check($sformatf("reset_write_access_%0d", i), wacc[i], 0);
            check($sformatf("reset_read_access_%0d", i), racc[i], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero wait states
        push_exp(0, RGGEN_WRITE, 32'hA5A5_0000, 32'hFFFF_FFFF, 1'b1, 1);
        drive(0, RGGEN_WRITE, 16'h0010, 32'hA5A5_0000, 32'hFFFF_FFFF, 4'd3);
        wait_resp(0, "a_write", 0, 1'b0);
        push_exp(0, RGGEN_READ, 32'h0, 32'h0, 1'b1, 1);
        drive(0, RGGEN_READ, 16'h0013, 32'h0, 32'h0, 4'd3);
        wait_resp(0, "a_read", 0, 1'b0);
        push_exp(0, RGGEN_WRITE, 32'h1122_3344, 32'h0000_FFFF, 1'b1, 1);
        drive(0, RGGEN_WRITE, 16'h0012, 32'h1122_3344, 32'h0000_FFFF, 4'd3);
        wait_resp(0, "a_write_part", 0, 1'b0);
        drive(0, RGGEN_READ, 16'h0014, 32'h0, 32'h0, 4'd3);
        expect_silence(0, "a_out_of_range", 8);
        drive(0, RGGEN_READ, 16'h000F, 32'h0, 32'h0, 4'd3);
        expect_silence(0, "a_below_range", 8);
        drive(0, RGGEN_READ, 16'h0010, 32'h0, 32'h0, 4'd2);
        expect_silence(0, "a_index_miss", 8);
        check("a_value", rval[0], bf_value[0]);
        bf_value[0] = 32'hCAFE_0001;
        #1;
        check("a_value_change", rval[0], bf_value[0]);

        // three wait states, miss returns an error
        push_exp(1, RGGEN_READ, 32'h0, 32'h0, 1'b1, 4);
        drive(1, RGGEN_READ, 16'h0010, 32'h0, 32'h0, 4'd5);
        wait_resp(1, "b_read", 0, 1'b0);
        push_exp(1, RGGEN_READ, 32'h0, 32'h0, 1'b0, 4);
        drive(1, RGGEN_READ, 16'h0011, 32'h0, 32'h0, 4'd6);
        wait_resp(1, "b_read_err", 0, 1'b0);
        push_exp(1, RGGEN_WRITE, 32'h7777_8888, 32'hFFFF_FFFF, 1'b0, 4);
        drive(1, RGGEN_WRITE, 16'h0010, 32'h7777_8888, 32'hFFFF_FFFF, 4'd4);
        wait_resp(1, "b_write_err", 0, 1'b0);
        push_exp(1, RGGEN_WRITE, 32'h0BAD_F00D, 32'hFF00_FF00, 1'b1, 4);
        push_exp(1, RGGEN_WRITE, 32'h0BAD_F00D, 32'hFF00_FF00, 1'b1, 5);
        drive(1, RGGEN_WRITE, 16'h0013, 32'h0BAD_F00D, 32'hFF00_FF00, 4'd5);
        wait_resp(1, "b_b2b_first", 0, 1'b1);
        wait_resp(1, "b_b2b_second", 0, 1'b0);

        // masked index compare
        push_exp(2, RGGEN_READ, 32'h0, 32'h0, 1'b1, 5);
        drive(2, RGGEN_READ, 16'h0010, 32'h0, 32'h0, 4'b0111);
        wait_resp(2, "c_mask_hit", 0, 1'b0);
        drive(2, RGGEN_WRITE, 16'h0010, 32'h1, 32'hFFFF_FFFF, 4'b1000);
        expect_silence(2, "c_mask_miss", 12);

        // index changes after capture do not matter
        push_exp(2, RGGEN_WRITE, 32'hCAFE_BABE, 32'hFFFF_FFFF, 1'b1, 5);
        drive(2, RGGEN_WRITE, 16'h0011, 32'hCAFE_BABE, 32'hFFFF_FFFF, 4'b0100);
        @(posedge clk); #1;
        idx[2] = 4'b1000;
        wait_resp(2, "c_index_change", 1, 1'b0);

        // request withdrawn during wait states
        drive(2, RGGEN_WRITE, 16'h0010, 32'h2, 32'hFFFF_FFFF, 4'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        expect_silence(2, "c_abort", 10);
        push_exp(2, RGGEN_WRITE, 32'h3333_4444, 32'h0F0F_0F0F, 1'b1, 5);
        drive(2, RGGEN_WRITE, 16'h0010, 32'h3333_4444, 32'h0F0F_0F0F, 4'b0101);
        wait_resp(2, "c_after_abort", 0, 1'b0);

        // asynchronous reset while a response is on the bus
        drive(0, RGGEN_READ, 16'h0010, 32'h0, 32'h0, 4'd3);
        @(posedge clk); #1;
        check("a_pre_reset_ready", rdy[0], 1);
        rst_n = 1'b0;
        #1;
        check("a_async_reset_ready", rdy[0], 0);
        check("a_async_reset_read_access", racc[0], 0);
        check("a_async_reset_read_data", rdata[0], 0);
        check("a_async_reset_status", stat[0], RGGEN_OKAY);
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // asynchronous reset during wait states
        drive(2, RGGEN_WRITE, 16'h0010, 32'h5, 32'hFFFF_FFFF, 4'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("c_async_reset_ready", rdy[2], 0);
        check("c_async_reset_write_access", wacc[2], 0);
        expect_silence(2, "c_in_reset", 3);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(2, RGGEN_READ, 32'h0, 32'h0, 1'b1, 5);
        drive(2, RGGEN_READ, 16'h0012, 32'h0, 32'h0, 4'b0110);
        wait_resp(2, "c_after_reset", 0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
